instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Instruction fetch front-end that sits directly upstream of the single-cycle RISC-V datapath. It issues word-aligned fetch requests to a variable-latency instruction memory over a valid/ready request channel and an in-order response channel. Returned words are buffered with their PC in a DEPTH-entry FIFO and presented to the core over a valid/ready handshake. A branch, jal or jalr redirect from the datapath flushes the queue and discards any responses still in flight.

## Interface
- DEPTH, 4, FIFO entries and maximum outstanding requests; power of 2, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0

- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  32  fetch address; always word-aligned
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  response word valid; responses return in request order
- mem_rsp_data  in  32  instruction word
- inst_valid  out  1  head FIFO entry valid
- inst_data  out  32  head instruction word
- inst_pc  out  32  PC of head instruction
- inst_ready  in  1  core consumes the head entry
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0

## Operation
- State registers:
  - fetch_pc (32)
  - rsp_pc (32)
  - outstanding and discard_cnt, each $clog2(DEPTH)+1 bits
  - FIFO with count, rd_ptr and wr_ptr
  - started flag
- Reset values:
  - fetch_pc = rsp_pc = RESET_PC
  - all counters and pointers = 0
  - started = 0
- Output values during reset:
  - mem_req_valid = 0
  - mem_req_addr = RESET_PC
  - inst_valid = 0
  - inst_data = 0
  - inst_pc = 0
- started is set on the first clock edge after reset is released.
- Credit rule: mem_req_valid = started & !redirect & (count + outstanding < DEPTH). The FIFO therefore cannot overflow.
- mem_req_addr = fetch_pc.
- Request accepted (mem_req_valid & mem_req_ready): fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1.
- Response (mem_rsp_valid): outstanding −= 1.
  - If discard_cnt > 0: drop the word and decrement discard_cnt.
  - Otherwise: push {rsp_pc, mem_rsp_data} and rsp_pc += 4.
- mem_rsp_valid while outstanding == 0 is a protocol violation. It is ignored and no counter changes.
- Accepting a request and receiving a response in the same cycle leaves outstanding unchanged.
- Pop (inst_valid & inst_ready) advances rd_ptr. A push and a pop in the same cycle leave count unchanged.
- inst_valid = (count != 0). inst_data and inst_pc come from the head entry and are don't-care when inst_valid = 0 (except during reset).
- Redirect (highest priority, applied at the clock edge):
  - FIFO is flushed: count = 0 and pointers reset to 0.
  - fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - discard_cnt = outstanding − mem_rsp_valid. A response arriving in the redirect cycle is dropped.
  - outstanding = outstanding − mem_rsp_valid.
  - Any pop or push in that cycle is cancelled.
- Back-to-back redirects are legal; each one recomputes discard_cnt from the current outstanding count.

## Timing
- Request channel:
  - The first mem_req_valid is asserted one cycle after the first rising edge following reset release.
  - mem_req_valid is combinational from registered state and redirect, and is forced low in any cycle where redirect = 1.
  - Once asserted, mem_req_valid and mem_req_addr are held stable until accepted, unless a redirect occurs.
- Response to core: a word accepted on mem_rsp_valid in cycle N sets inst_valid in cycle N+1. There is no combinational pass-through.
- Redirect: inst_valid = 0 in cycle R+1, and the request to the new PC is issued no earlier than cycle R+1.
- Throughput: with zero-latency memory and inst_ready held at 1, the block sustains one instruction per cycle in steady state.
- Reset asserted mid-operation clears all state immediately (asynchronously). Memory responses still in flight at that point are the memory's responsibility to squash.

## Test plan
- Reset release, RESET_PC = 0, memory ready at 1-cycle latency, inst_ready = 1 → requests go out to 0x0, 0x4, 0x8, …; inst_pc sequence is 0x0, 0x4, 0x8 with the matching data and no gaps after warm-up.
- inst_ready = 0 with DEPTH = 4 → exactly 4 requests are accepted, then mem_req_valid = 0. Raising inst_ready for one cycle produces exactly one new request.
- Memory latency 3 with 3 requests outstanding, redirect to 0x103 → the next request address is 0x100, the 3 stale responses are dropped, and the first inst_pc after the redirect is 0x100.
- Redirect in the same cycle as mem_rsp_valid and a core pop → that response is dropped, discard_cnt = outstanding − 1, and inst_valid = 0 on the next cycle.
- fetch_pc = 0xFFFF_FFFC → the following request address is 0x0000_0000, and the inst_pc sequence wraps the same way.
- RST_N asserted with the FIFO half full and 2 requests outstanding → all outputs take their reset values immediately. After release the first request goes to RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: issues word-aligned fetches under a credit limit,
// buffers in-order responses with their PC and flushes on redirect.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          started;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];

  logic          req_fire;
  logic          rsp_ok;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_used;

  // Handshake decode; a response with nothing outstanding is ignored entirely.
  always_comb begin
    credit_used   = {1'b0, count} + {1'b0, outstanding};
    mem_req_valid = started & ~redirect & (credit_used < DEPTH_W);
    req_fire      = mem_req_valid & mem_req_ready;
    rsp_ok        = mem_rsp_valid & (outstanding != '0);
    push          = rsp_ok & (discard_cnt == '0);
    pop           = (count != '0) & inst_ready;
  end

  assign mem_req_addr = fetch_pc;
  assign inst_valid   = (count != '0);
  assign inst_data    = fifo_data[rd_ptr];
  assign inst_pc      = fifo_pc[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      started     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_pc[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      started <= 1'b1;
      if (redirect) begin
        // In-flight responses (minus one arriving now) become stale and are dropped.
        fetch_pc    <= {redirect_pc[31:2], 2'b00};
        rsp_pc      <= {redirect_pc[31:2], 2'b00};
        outstanding <= outstanding - CW'(rsp_ok);
        discard_cnt <= outstanding - CW'(rsp_ok);
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
        if (rsp_ok && (discard_cnt != '0)) discard_cnt <= discard_cnt - CW'(1);
        if (push) begin
          fifo_pc[wr_ptr]   <= rsp_pc;
          fifo_data[wr_ptr] <= mem_rsp_data;
          wr_ptr            <= wr_ptr + AW'(1);
          rsp_pc            <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: in-order variable-latency memory model with an
// independent fetch-address model and a scoreboard of expected {pc, word}.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] rpc; int lat; bit rand_rdy; logic [31:0] exp_addr; } rvec_t;

  mreq_t pend[$];
  exp_t  sb[$];
  int    total = 0, bad = 0, cyc = 0, lat = 1, accepts = 0, pops = 0;
  bit    ir = 1'b1, rdy_rand = 1'b0, redir = 1'b0, prev_stall = 1'b0;
  logic [31:0] rpc = '0, exp_next = RESET_PC, last_acc = '0, first_pop = '0, prev_addr = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_addr = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at posedge+1, sample at negedge, update models.
  task automatic tick();
    exp_t e;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = word_of(pend[0].addr);
      void'(pend.pop_front());
    end
    mem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    inst_ready    = ir;
    redirect      = redir;
    redirect_pc   = rpc;
    #4;
    if (prev_stall && !redirect) begin
      check("req_hold_valid", 32'(mem_req_valid), 32'd1);
      check("req_hold_addr", mem_req_addr, prev_addr);
    end
    if (redirect) begin
      check("req_low_on_redirect", 32'(mem_req_valid), 32'd0);
      sb.delete();
      exp_next = {rpc[31:2], 2'b00};
    end else if (inst_valid && inst_ready) begin
      if (pops == 0) first_pop = inst_pc;
      pops++;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL pop_unexpected: got pc %h want no entry", inst_pc);
      end else begin
        e = sb.pop_front();
        check("pop_pc", inst_pc, e.pc);
        check("pop_data", inst_data, e.data);
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      check("req_addr", mem_req_addr, exp_next);
      pend.push_back('{mem_req_addr, cyc + lat});
      sb.push_back('{exp_next, word_of(exp_next)});
      exp_next = exp_next + 32'd4;
      accepts++;
      last_acc = mem_req_addr;
    end
    prev_stall = mem_req_valid && !mem_req_ready;
    prev_addr  = mem_req_addr;
    s_valid    = mem_req_valid;
    s_addr     = mem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redir = 1'b0; redirect = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    #1;
    pend.delete(); sb.delete(); prev_stall = 1'b0; exp_next = RESET_PC;
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_req_addr", mem_req_addr, RESET_PC);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("valid_before_started", 32'(s_valid), 32'd0);
    tick();
    check("first_req_valid", 32'(s_valid), 32'd1);
    check("first_req_addr", s_addr, RESET_PC);
  endtask

  rvec_t vt[5];

  initial begin
    vt[0] = '{32'h0000_0103, 3, 1'b0, 32'h0000_0100};
    vt[1] = '{32'h0000_2000, 1, 1'b0, 32'h0000_2000};
    vt[2] = '{32'hFFFF_FFF9, 2, 1'b0, 32'hFFFF_FFF8};
    vt[3] = '{32'h8000_0002, 2, 1'b1, 32'h8000_0000};
    vt[4] = '{32'h0000_0044, 3, 1'b1, 32'h0000_0044};

    rst_n = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #3;

    // Streaming at latency 1: one instruction per cycle after warm-up.
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    pops = 0;
    for (int i = 0; i < 20; i++) tick();
    check("throughput_pops", 32'(pops), 32'd20);

    // Core stalled: credit caps requests at DEPTH; one pop frees one request.
    ir = 1'b0; accepts = 0;
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    check("stall_accepts", 32'(accepts), 32'(DEPTH));
    check("stall_req_valid", 32'(s_valid), 32'd0);
    ir = 1'b1; tick(); ir = 1'b0; accepts = 0;
    for (int i = 0; i < 8; i++) tick();
    check("one_pop_one_req", 32'(accepts), 32'd1);
    check("one_pop_req_addr", last_acc, 32'h0000_0010);
    ir = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // Redirect vectors: stale responses dropped, fetch restarts at aligned PC.
    for (int k = 0; k < 5; k++) begin
      lat = vt[k].lat; rdy_rand = vt[k].rand_rdy; ir = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      redir = 1'b1; rpc = vt[k].rpc;
      tick();
      redir = 1'b0;
      check("redir_inst_valid_next", 32'(inst_valid), 32'd0);
      check("redir_addr_next", mem_req_addr, vt[k].exp_addr);
      pops = 0;
      for (int i = 0; i < 16; i++) tick();
      check("redir_first_pc", first_pop, vt[k].exp_addr);
    end
    rdy_rand = 1'b0;

    // Back-to-back redirects: the second target wins.
    lat = 2;
    for (int i = 0; i < 8; i++) tick();
    redir = 1'b1; rpc = 32'h0000_0300; tick();
    rpc = 32'h0000_0400; tick();
    redir = 1'b0; pops = 0;
    for (int i = 0; i < 16; i++) tick();
    check("b2b_redir_first_pc", first_pop, 32'h0000_0400);

    // Reset mid-operation with entries buffered and requests in flight.
    ir = 1'b0;
    for (int i = 0; i < 2; i++) tick();
    ir = 1'b1; lat = 1;
    do_reset();
    for (int i = 0; i < 10; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
